ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single data port of the 32-bit main RAM between the j1 CPU data path and a secondary DMA/debug master, such as a UART loader.
- Fixed priority goes to the CPU, with a starvation guard and a burst lock for the DMA master.
- Sits between the masters and the RAM's synchronous read/write port; instruction fetch is untouched.
- Read data returns with a fixed one-cycle latency, tagged to the master that issued the read.

Parameters:
- AW, 13, word-address width (8192 x 32 RAM).
- DW, 32, data width.
- STARVE_LIMIT, 4, cycles DMA may wait while CPU holds the port before DMA is forced through (0 = DMA always wins).

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetq  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- dma_req  in  1  DMA access request.
- dma_we  in  1  DMA write/read.
- dma_lock  in  1  DMA holds the port for consecutive beats.
- dma_addr  in  AW  DMA word address.
- dma_wdata  in  DW  DMA write data.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rvalid  out  1  DMA read data valid.
- rdata  out  DW  read data, shared by both masters, qualified by *_rvalid.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid one cycle after a read strobe.

Behaviour:

Reset:
- Asynchronous on resetq low.
- wait_cnt=0, locked=0, cpu_rvalid=0, dma_rvalid=0.
- Grants are combinational: 0 whenever no request is present.
- A read in flight when reset asserts is discarded; no rvalid follows reset release.

Grant decision (combinational from requests and registered state):
- dma_win = dma_req & (locked | wait_cnt==STARVE_LIMIT | ~cpu_req).
- dma_gnt = dma_win; cpu_gnt = cpu_req & ~dma_win.
- At most one grant per cycle. A request is held by the master (address/data stable) until its gnt is sampled high.

RAM drive:
- ram_en = cpu_gnt|dma_gnt.
- ram_we/ram_addr/ram_wdata are muxed from the winner; they select CPU fields when idle.

Starvation counter:
- If dma_req & ~dma_gnt: wait_cnt increments, saturating at STARVE_LIMIT.
- If dma_gnt or ~dma_req: wait_cnt = 0.

Lock:
- locked <= dma_gnt & dma_lock.
- locked clears the first cycle after DMA is granted with dma_lock=0, or when DMA does not request.
- While locked, the CPU sees cpu_gnt=0 regardless of wait state.

Read return:
- cpu_rvalid <= cpu_gnt & ~cpu_we.
- dma_rvalid <= dma_gnt & ~dma_we.
- rdata = ram_rdata, passed through combinationally.
- Writes produce no rvalid.
- Back-to-back reads from alternating masters return in issue order, one per cycle.

Boundary cases:
- Simultaneous requests with wait_cnt < STARVE_LIMIT and not locked: CPU wins.
- STARVE_LIMIT=0: DMA wins every conflict.
- Address wrap is the caller's concern; the arbiter passes AW bits unchanged.

Test Plan:
- Reset: hold resetq=0 with both req=1 -> no rvalid; outputs cpu_rvalid=0, dma_rvalid=0; first cycle after release, CPU read at 0x0010 -> cpu_gnt=1, ram_addr=0x0010, cpu_rvalid=1 next cycle with rdata=RAM[0x0010].
- Priority: cpu_req and dma_req held continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, DMA granted on 5th, then pattern repeats (CPU x4, DMA x1).
- Lock burst: DMA writes 0xA5A50000..0xA5A50003 to 0x100..0x103 with dma_lock=1 on first three beats, cpu_req=1 throughout -> DMA granted 4 consecutive cycles, CPU granted cycle after, RAM holds the 4 words.
- Read tagging: CPU read 0x20 then DMA read 0x21 on consecutive cycles (no conflict) -> cpu_rvalid cycle N+1 with RAM[0x20], dma_rvalid cycle N+2 with RAM[0x21], never both high.
- Write no-echo: CPU write 0xDEADBEEF to 0x1FFF -> no cpu_rvalid; subsequent CPU read of 0x1FFF returns 0xDEADBEEF.
- Mid-read reset: DMA read granted, resetq pulsed low before next edge -> dma_rvalid stays 0, wait_cnt=0 after release.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single data port of the main RAM between the CPU data path and a
// secondary DMA/debug master. The CPU has fixed priority. A starvation counter
// forces the DMA master through after STARVE_LIMIT lost cycles, and a lock bit
// lets the DMA master keep the port for consecutive burst beats. Read data
// comes straight from the RAM one cycle after the strobe, and a registered
// per-master valid tags it to the master that issued the read.

module ram_port_arbiter #(
    parameter int AW           = 13,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          resetq,
    // CPU data master
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    // DMA / debug master
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    // Shared read data
    output logic [DW-1:0] rdata,
    // RAM port
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    // The counter needs at least one bit. It must also hold the value
    // STARVE_LIMIT itself, because it saturates there.
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

    lock_state_t   lock_r;
    lock_state_t   lock_nxt_s;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_nxt_s;
    logic          starved_s;
    logic          dma_win_s;
    logic          cpu_win_s;
    logic          cpu_rvalid_r;
    logic          dma_rvalid_r;

    // Grant decision: DMA wins if it is locked, starved, or uncontested.
    always_comb begin
        starved_s = (wait_cnt_r == LIMIT);
        dma_win_s = dma_req & ((lock_r == LK_HELD) | starved_s | ~cpu_req);
        cpu_win_s = cpu_req & ~dma_win_s;
    end

    assign cpu_gnt = cpu_win_s;
    assign dma_gnt = dma_win_s;

    // RAM port mux: the winner drives the port, and CPU fields are shown when idle.
    always_comb begin
        ram_en = cpu_win_s | dma_win_s;
        if (dma_win_s) begin
            ram_we    = dma_we;
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
        end else begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
    end

    // Next-state logic for the burst lock and the starvation counter.
    always_comb begin
        lock_nxt_s     = LK_OPEN;
        wait_cnt_nxt_s = {CW{1'b0}};
        case (lock_r)
            LK_OPEN: begin
                if (dma_win_s && dma_lock) begin
                    lock_nxt_s = LK_HELD;
                end else begin
                    lock_nxt_s = LK_OPEN;
                end
            end
            LK_HELD: begin
                // Held only while DMA keeps requesting with dma_lock set.
                if (dma_win_s && dma_lock) begin
                    lock_nxt_s = LK_HELD;
                end else begin
                    lock_nxt_s = LK_OPEN;
                end
            end
            default: begin
                lock_nxt_s = LK_OPEN;
            end
        endcase

        if (dma_req && !dma_win_s) begin
            if (wait_cnt_r != LIMIT) begin
                wait_cnt_nxt_s = wait_cnt_r + CW'(1'b1);
            end else begin
                wait_cnt_nxt_s = wait_cnt_r;
            end
        end else begin
            wait_cnt_nxt_s = {CW{1'b0}};
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            lock_r     <= LK_OPEN;
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            lock_r     <= lock_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Read-return tags line up with the RAM's one-cycle read latency.
    // Reset drops any read that is in flight.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cpu_rvalid_r <= 1'b0;
            dma_rvalid_r <= 1'b0;
        end else begin
            cpu_rvalid_r <= cpu_win_s & ~cpu_we;
            dma_rvalid_r <= dma_win_s & ~dma_we;
        end
    end

    assign cpu_rvalid = cpu_rvalid_r;
    assign dma_rvalid = dma_rvalid_r;
    assign rdata      = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter. A behavioural synchronous RAM sits behind
// the arbiter. A small reference model predicts the grants and the RAM port
// fields, and it queues the expected read returns. A negedge monitor checks
// the DUT against the model every cycle. Table-driven single-cycle vectors and
// hand-written multi-cycle sequences cover priority, lock, tagging and reset.

module tb_ram_port_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          resetq;
    logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // Second instance with STARVE_LIMIT=0 shares the inputs.
    logic          d0_cpu_gnt, d0_cpu_rvalid, d0_dma_gnt, d0_dma_rvalid;
    logic [DW-1:0] d0_rdata, d0_ram_wdata;
    logic          d0_ram_en, d0_ram_we;
    logic [AW-1:0] d0_ram_addr;

    int total = 0;
    int bad   = 0;

    ram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) u_dut (
        .clk(clk), .resetq(resetq),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(0)) u_dut0 (
        .clk(clk), .resetq(resetq),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(d0_cpu_gnt), .cpu_rvalid(d0_cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(d0_dma_gnt), .dma_rvalid(d0_dma_rvalid),
        .rdata(d0_rdata), .ram_en(d0_ram_en), .ram_we(d0_ram_we), .ram_addr(d0_ram_addr),
        .ram_wdata(d0_ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [12:0] a);
        return {16'hC0DE, 3'b000, a};
    endfunction

    function automatic logic [31:0] wd(input logic [12:0] a);
        return {16'h5A5A, 3'b000, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural RAM (read-first) and the reference copy of its contents.
    logic [31:0] mem     [8192];
    logic [31:0] ref_mem [8192];

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]     <= init_word(13'(i));
            ref_mem[i] <= init_word(13'(i));
        end
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // Reference model state and the scoreboard of expected read returns.
    typedef struct {
        logic        is_dma;
        logic [31:0] data;
    } rd_exp_t;
    rd_exp_t exp_q[$];
    int   m_wait;
    logic m_locked;

    function automatic logic model_dwin();
        return dma_req & (m_locked | (m_wait == LIM) | ~cpu_req);
    endfunction

    always @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            m_wait   <= 0;
            m_locked <= 1'b0;
            exp_q.delete();
        end else begin
            logic dw, cw;
            rd_exp_t e;
            dw = model_dwin();
            cw = cpu_req & ~dw;
            if (dw && !dma_we) begin
                e.is_dma = 1'b1; e.data = ref_mem[dma_addr]; exp_q.push_back(e);
            end
            if (cw && !cpu_we) begin
                e.is_dma = 1'b0; e.data = ref_mem[cpu_addr]; exp_q.push_back(e);
            end
            if (dw && dma_we) ref_mem[dma_addr] <= dma_wdata;
            if (cw && cpu_we) ref_mem[cpu_addr] <= cpu_wdata;
            m_locked <= dw & dma_lock;
            if (dma_req && !dw) m_wait <= (m_wait == LIM) ? LIM : m_wait + 1;
            else m_wait <= 0;
        end
    end

    // Per-cycle monitor: grants, the RAM port and the tagged read returns.
    always @(negedge clk) begin
        logic dw, cw;
        rd_exp_t e;
        dw = model_dwin();
        cw = cpu_req & ~dw;
        chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, cw});
        chk("dma_gnt", {31'd0, dma_gnt}, {31'd0, dw});
        chk("ram_en", {31'd0, ram_en}, {31'd0, cw | dw});
        chk("ram_addr", {19'd0, ram_addr}, {19'd0, dw ? dma_addr : cpu_addr});
        chk("ram_we", {31'd0, ram_we}, {31'd0, dw ? dma_we : cpu_we});
        if (cw | dw) chk("ram_wdata", ram_wdata, dw ? dma_wdata : cpu_wdata);
        chk("lim0_dma_gnt", {31'd0, d0_dma_gnt}, {31'd0, dma_req});
        chk("lim0_cpu_gnt", {31'd0, d0_cpu_gnt}, {31'd0, cpu_req & ~dma_req});
        chk("lim0_ram_en", {31'd0, d0_ram_en}, {31'd0, cpu_req | dma_req});
        if (!resetq || exp_q.size() == 0) begin
            chk("no_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("rvalid_tag", {30'd0, cpu_rvalid, dma_rvalid},
                e.is_dma ? 32'd1 : 32'd2);
            chk("rdata", rdata, e.data);
        end
    end

    // Drive one cycle of stimulus just after the rising edge. Return at the falling edge.
    task automatic cyc(input logic cr, input logic cwe, input logic [12:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dwe, input logic dl, input logic [12:0] da,
                       input logic [31:0] dd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dwe; dma_lock = dl; dma_addr = da; dma_wdata = dd;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 13'h0, 32'h0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
    endtask

    typedef struct {
        logic        cr, cw, dr, dw, dl;
        logic [12:0] ca, da;
        logic        ecg, edg, ewe;
        logic [12:0] eaddr;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] hist_d, hist_c;

        //        cr    cw    dr    dw    dl    ca      da      ecg   edg   ewe   eaddr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h010, 13'h000, 1'b1, 1'b0, 1'b0, 13'h010};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h000, 13'h011, 1'b0, 1'b1, 1'b0, 13'h011};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'h012, 13'h013, 1'b1, 1'b0, 1'b0, 13'h012};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 13'h014, 13'h015, 1'b1, 1'b0, 1'b1, 13'h014};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 13'h000, 13'h016, 1'b0, 1'b1, 1'b1, 13'h016};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h017, 13'h018, 1'b0, 1'b0, 1'b0, 13'h017};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h019, 13'h01A, 1'b0, 1'b1, 1'b0, 13'h01A};

        // Reset held with both masters requesting.
        resetq = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010; cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 13'h011; dma_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);

        // First cycle after release: CPU read of 0x0010.
        @(posedge clk);
        #1;
        resetq = 1'b1;
        dma_req = 1'b0;
        @(negedge clk);
        chk("rel_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        chk("rel_ram_addr", {19'd0, ram_addr}, 32'h0010);
        idle();
        chk("rel_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("rel_rdata", rdata, 32'hC0DE_0010);

        // Table of single-cycle vectors, each followed by an idle cycle.
        for (int i = 0; i < 7; i++) begin
            cyc(vecs[i].cr, vecs[i].cw, vecs[i].ca, wd(vecs[i].ca),
                vecs[i].dr, vecs[i].dw, vecs[i].dl, vecs[i].da, wd(vecs[i].da));
            chk($sformatf("vec%0d_cpu_gnt", i), {31'd0, cpu_gnt}, {31'd0, vecs[i].ecg});
            chk($sformatf("vec%0d_dma_gnt", i), {31'd0, dma_gnt}, {31'd0, vecs[i].edg});
            chk($sformatf("vec%0d_ram_we", i), {31'd0, ram_we}, {31'd0, vecs[i].ewe});
            chk($sformatf("vec%0d_ram_addr", i), {19'd0, ram_addr}, {19'd0, vecs[i].eaddr});
            chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, wd(vecs[i].eaddr));
            idle();
        end

        // Priority with both masters requesting: CPU x4, DMA x1, repeating.
        hist_d = 15'd0; hist_c = 15'd0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 1'b0, 13'h040, 32'h0, 1'b1, 1'b0, 1'b0, 13'h041, 32'h0);
            hist_d[i] = dma_gnt;
            hist_c[i] = cpu_gnt;
        end
        chk("prio_dma_hist", {17'd0, hist_d}, 32'h4210);
        chk("prio_cpu_hist", {17'd0, hist_c}, 32'h3DEF);
        idle();
        idle();

        // Lock burst: the first beat waits out starvation, and the rest ride the lock.
        begin
            int beat;
            beat = 0; hist_d = 15'd0; hist_c = 15'd0;
            for (int i = 0; i < 9; i++) begin
                cyc(1'b1, 1'b0, 13'h030, 32'h0,
                    (beat < 4) ? 1'b1 : 1'b0, 1'b1, (beat < 3) ? 1'b1 : 1'b0,
                    13'(13'h100 + beat), 32'hA5A5_0000 + 32'(beat));
                hist_d[i] = dma_gnt;
                hist_c[i] = cpu_gnt;
                if (dma_gnt) beat++;
            end
            chk("lock_dma_hist", {17'd0, hist_d}, 32'h00F0);
            chk("lock_cpu_hist", {17'd0, hist_c}, 32'h010F);
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 13'(13'h100 + i), 32'h0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
            idle();
            chk($sformatf("burst_rd%0d", i), rdata, 32'hA5A5_0000 + 32'(i));
        end

        // Read tagging across masters on consecutive cycles.
        cyc(1'b1, 1'b0, 13'h020, 32'h0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
        cyc(1'b0, 1'b0, 13'h0, 32'h0, 1'b1, 1'b0, 1'b0, 13'h021, 32'h0);
        chk("tag_n1", {30'd0, cpu_rvalid, dma_rvalid}, 32'd2);
        chk("tag_n1_data", rdata, 32'hC0DE_0020);
        idle();
        chk("tag_n2", {30'd0, cpu_rvalid, dma_rvalid}, 32'd1);
        chk("tag_n2_data", rdata, 32'hC0DE_0021);

        // A write gives no echo, and a later read returns the written data.
        cyc(1'b1, 1'b1, 13'h1FFF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
        idle();
        chk("wr_no_echo", {31'd0, cpu_rvalid}, 32'd0);
        cyc(1'b1, 1'b0, 13'h1FFF, 32'h0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
        idle();
        chk("wr_readback_v", {31'd0, cpu_rvalid}, 32'd1);
        chk("wr_readback", rdata, 32'hDEAD_BEEF);

        // Mid-read reset: the granted DMA read is dropped.
        cyc(1'b0, 1'b0, 13'h0, 32'h0, 1'b1, 1'b0, 1'b0, 13'h021, 32'h0);
        chk("mid_dma_gnt", {31'd0, dma_gnt}, 32'd1);
        #1;
        resetq = 1'b0;
        dma_req = 1'b0;
        #2;
        resetq = 1'b1;
        idle();
        chk("mid_no_rvalid", {31'd0, dma_rvalid}, 32'd0);
        hist_d = 15'd0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 13'h040, 32'h0, 1'b1, 1'b0, 1'b0, 13'h041, 32'h0);
            hist_d[i] = dma_gnt;
        end
        chk("mid_wait_cleared", {17'd0, hist_d}, 32'h0010);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
